// File: rtl/alu_core.sv
// Sequential ALU: single-cycle add/sub/logic, iterative shifts and an optional
// shift-add multiplier (compiled in when ALU_MUL_EN is defined).
module alu_core #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             illegal
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      EXEC   = 3'd1,
      SHIFT  = 3'd2,
      MUL    = 3'd3,
      FINISH = 3'd4
   } state_t;

   state_t             state, state_n;
   logic [2:0]         op_q, op_n;
   logic [WIDTH-1:0]   wa, wa_n;
   logic [WIDTH-1:0]   wb, wb_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               cy_w, cy_n;
   logic               ill_w, ill_n;
   logic [WIDTH-1:0]   fin_res_c;
   logic               fin_cy_c;
`ifdef ALU_MUL_EN
   logic [WIDTH-1:0]   acc, acc_n;
   logic [WIDTH:0]     sum_c;
`endif

   // Next-state and working-register update
   always_comb begin
      state_n   = state;
      op_n      = op_q;
      wa_n      = wa;
      wb_n      = wb;
      cnt_n     = cnt;
      cy_n      = cy_w;
      ill_n     = ill_w;
      fin_res_c = wa;
      fin_cy_c  = cy_w;
`ifdef ALU_MUL_EN
      acc_n     = acc;
      sum_c     = '0;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               op_n  = op;
               wa_n  = a;
               wb_n  = b;
               cy_n  = 1'b0;
               ill_n = 1'b0;
`ifdef ALU_MUL_EN
               acc_n = '0;
`endif
               case (op)
                  OP_SHL, OP_SHR: begin
                     cnt_n   = CNT_W'(b[2:0]);
                     state_n = SHIFT;
                  end
`ifdef ALU_MUL_EN
                  OP_MUL: begin
                     cnt_n   = CNT_W'(WIDTH);
                     state_n = MUL;
                  end
`endif
                  // Unimplemented MUL passes through EXEC to keep the 2-cycle latency
                  default: state_n = EXEC;
               endcase
            end
         end
         EXEC: begin
            state_n = FINISH;
            case (op_q)
               OP_ADD: {cy_n, wa_n} = (WIDTH + 1)'(wa) + (WIDTH + 1)'(wb);
               OP_SUB: begin
                  wa_n = wa - wb;
                  cy_n = (wa < wb);
               end
               OP_AND: begin
                  wa_n = wa & wb;
                  cy_n = 1'b0;
               end
               OP_OR: begin
                  wa_n = wa | wb;
                  cy_n = 1'b0;
               end
               OP_XOR: begin
                  wa_n = wa ^ wb;
                  cy_n = 1'b0;
               end
               default: begin
                  wa_n  = '0;
                  cy_n  = 1'b0;
                  ill_n = 1'b1;
               end
            endcase
         end
         SHIFT: begin
            if (cnt == '0) begin
               state_n = FINISH;
            end else begin
               cnt_n = cnt - CNT_W'(1);
               if (op_q == OP_SHL) begin
                  cy_n = wa[WIDTH-1];
                  wa_n = {wa[WIDTH-2:0], 1'b0};
               end else begin
                  cy_n = wa[0];
                  wa_n = {1'b0, wa[WIDTH-1:1]};
               end
            end
         end
`ifdef ALU_MUL_EN
         // {acc, wb} is the product register; wb's LSB selects the add
         MUL: begin
            if (cnt == '0) begin
               state_n = FINISH;
            end else begin
               cnt_n = cnt - CNT_W'(1);
               sum_c = wb[0] ? (WIDTH + 1)'(acc) + (WIDTH + 1)'(wa) : (WIDTH + 1)'(acc);
               acc_n = sum_c[WIDTH:1];
               wb_n  = {sum_c[0], wb[WIDTH-1:1]};
            end
         end
`endif
         FINISH: begin
            state_n = IDLE;
`ifdef ALU_MUL_EN
            if (op_q == OP_MUL) begin
               fin_res_c = wb;
               fin_cy_c  = |acc;
            end
`endif
         end
         default: state_n = IDLE;
      endcase
   end

   // State, working registers and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         op_q    <= '0;
         wa      <= '0;
         wb      <= '0;
         cnt     <= '0;
         cy_w    <= 1'b0;
         ill_w   <= 1'b0;
`ifdef ALU_MUL_EN
         acc     <= '0;
`endif
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         zero    <= 1'b1;
         carry   <= 1'b0;
         illegal <= 1'b0;
      end else begin
         state <= state_n;
         op_q  <= op_n;
         wa    <= wa_n;
         wb    <= wb_n;
         cnt   <= cnt_n;
         cy_w  <= cy_n;
         ill_w <= ill_n;
`ifdef ALU_MUL_EN
         acc   <= acc_n;
`endif
         busy  <= (state_n != IDLE);
         done  <= (state == FINISH);
         if (state == FINISH) begin
            result  <= fin_res_c;
            zero    <= (fin_res_c == '0);
            carry   <= fin_cy_c;
            illegal <= ill_w;
         end
      end
   end

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core; expected completions queued at issue,
// compared when done pulses. Honors ALU_MUL_EN like the design.
module tb_alu_core;

   logic       clk;
   logic       reset;
   logic       start;
   logic [2:0] op;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       zero;
   logic       carry;
   logic       illegal;

   typedef struct {
      logic [7:0] res;
      logic       z;
      logic       c;
      logic       ill;
      int         lat;
      int         due;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   last_n = 0;

   alu_core #(.WIDTH(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .zero    (zero),
      .carry   (carry),
      .illegal (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
      exp_t       e;
      logic [8:0] s;
      logic [15:0] p;
      int         k;
      e.res = 8'h00; e.c = 1'b0; e.ill = 1'b0; e.lat = 2; e.due = 0;
      k = int'(y[2:0]);
      case (o)
         3'd0: begin s = {1'b0, x} + {1'b0, y}; e.res = s[7:0]; e.c = s[8]; end
         3'd1: begin e.res = x - y; e.c = (x < y); end
         3'd2: e.res = x & y;
         3'd3: e.res = x | y;
         3'd4: e.res = x ^ y;
         3'd5: begin
            e.res = x << k;
            e.c   = (k == 0) ? 1'b0 : x[8 - k];
            e.lat = 2 + k;
         end
         3'd6: begin
            e.res = x >> k;
            e.c   = (k == 0) ? 1'b0 : x[k - 1];
            e.lat = 2 + k;
         end
         default: begin
`ifdef ALU_MUL_EN
            p     = 16'(x) * 16'(y);
            e.res = p[7:0];
            e.c   = |p[15:8];
            e.lat = 10;
`else
            p     = 16'h0;
            e.res = p[7:0];
            e.ill = 1'b1;
`endif
         end
      endcase
      e.z = (e.res == 8'h00);
      return e;
   endfunction

   // Issue one operation as soon as the ALU is idle; optionally queue its result
   task automatic do_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input bit push);
      exp_t e;
      bit   ok;
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("idle_timeout", 0, 1);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      #1;
      last_n = cyc;
      start = 1'b0;
      if (push) begin
         e = model(o, x, y);
         e.due = last_n + e.lat;
         sb.push_back(e);
      end
   endtask

   // Completion monitor
   always @(posedge clk) begin
      exp_t e;
      cyc = cyc + 1;
      #1;
      if (done) begin
         if (sb.size() == 0) begin
            check("spurious_done", 1, 0);
         end else begin
            e = sb.pop_front();
            check("result", result, e.res);
            check("zero", zero, e.z);
            check("carry", carry, e.c);
            check("illegal", illegal, e.ill);
            check("latency", cyc, e.due);
            check("busy_at_done", busy, 0);
         end
      end
   end

   initial begin
      logic [2:0] po;
      logic [7:0] pa, pb;
      int         plat;
      logic [2:0] ro;
      bit         drained;

      reset = 1'b1; start = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 8'h00);
      check("rst_zero", zero, 1);
      check("rst_carry", carry, 0);
      check("rst_illegal", illegal, 0);
      @(negedge clk);
      reset = 1'b0;

      do_op(3'd0, 8'hF0, 8'h20, 1'b1);
      do_op(3'd1, 8'h05, 8'h05, 1'b1);
      do_op(3'd1, 8'h03, 8'h04, 1'b1);
      do_op(3'd5, 8'h81, 8'h03, 1'b1);
      do_op(3'd6, 8'h81, 8'h00, 1'b1);
      do_op(3'd7, 8'h10, 8'h11, 1'b1);

      // Long operation with a stray start and operand churn while busy
`ifdef ALU_MUL_EN
      po = 3'd7; pa = 8'h10; pb = 8'h11; plat = 10;
`else
      po = 3'd5; pa = 8'h81; pb = 8'h07; plat = 9;
`endif
      do_op(po, pa, pb, 1'b1);
      for (int i = 0; i < plat; i++) begin
         @(negedge clk);
         check("busy_hold", busy, 1);
         if (i == 2) begin
            start = 1'b1; op = 3'd0; a = 8'h55; b = 8'hAA;
         end else begin
            start = 1'b0; a = 8'(i * 37); b = 8'(i * 11);
         end
      end
      start = 1'b0;

      // Reset during SHL k=7 aborts without a completion
      do_op(3'd5, 8'h81, 8'h07, 1'b0);
      for (int i = 0; i < 4; i++) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_result", result, 8'h00);
      check("abort_zero", zero, 1);
      check("abort_carry", carry, 0);
      @(negedge clk);
      reset = 1'b0;
      do_op(3'd0, 8'h12, 8'h34, 1'b1);

      for (int i = 0; i < 24; i++) begin
         ro = 3'($urandom_range(0, 7));
         do_op(ro, 8'($urandom), 8'($urandom), 1'b1);
      end

      drained = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (sb.size() == 0) begin
            drained = 1'b1;
            break;
         end
      end
      if (!drained) check("drain_timeout", sb.size(), 0);
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
